reg_bank_scan: RTL and testbench

Parametrised successor to the single-bank data register used by the 7-segment display path. A value is staged with save_data and committed to one of DEPTH registers with write_en, using the address carried on d_in. A register can be shown on demand with show_reg, or all registers can be auto-scanned for multiplexed display. The block sits between the switch/button inputs and the 7-segment decoder; its buttons are edge-triggered internally.

---
 rtl/reg_bank_scan.sv | 97 +++++++++
 tb/tb_reg_bank_scan.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_scan.sv
// Staged register bank for the 7-segment path.
// Writes are button-edge triggered; the display shows hold, one selected register or a timed scan.
module reg_bank_scan #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SCAN_DIV = 4,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_data,
  input  logic              write_en,
  input  logic              show_reg,
  input  logic              scan_en,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic [ADDR_W-1:0] d_addr,
  output logic              wr_ack,
  output logic              err
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SCAN_DIV - 1);

  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] bank_q [DEPTH];
  logic [ADDR_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic              prev_save_q, prev_wr_q;

  logic [ADDR_W-1:0] addr;
  logic              addr_ok;
  logic              save_ev, wr_ev;
  logic [DATA_W-1:0] sel_data;
  logic [ADDR_W-1:0] sel_addr;

  assign addr    = d_in[ADDR_W-1:0];
  // Address field can encode values past the last register when DEPTH is not a power of two.
  assign addr_ok = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign save_ev = save_data & ~prev_save_q;
  assign wr_ev   = write_en & ~prev_wr_q;

  always_comb begin
    sel_data = hold_q;
    sel_addr = '0;
    if (show_reg) begin
      sel_addr = addr;
      sel_data = addr_ok ? bank_q[addr] : '0;
    end else if (scan_en) begin
      sel_addr = scan_ptr_q;
      sel_data = bank_q[scan_ptr_q];
    end
  end

  // Scan restarts from register 0 whenever it is not actively running.
  always_comb begin
    div_cnt_d  = '0;
    scan_ptr_d = '0;
    if (scan_en && !show_reg) begin
      if (div_cnt_q == LAST_CNT) begin
        scan_ptr_d = (scan_ptr_q == LAST_PTR) ? '0 : scan_ptr_q + 1'b1;
      end else begin
        div_cnt_d  = div_cnt_q + 1'b1;
        scan_ptr_d = scan_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      scan_ptr_q  <= '0;
      div_cnt_q   <= '0;
      prev_save_q <= 1'b0;
      prev_wr_q   <= 1'b0;
      d_out       <= '0;
      d_addr      <= '0;
      wr_ack      <= 1'b0;
      err         <= 1'b0;
    end else begin
      prev_save_q <= save_data;
      prev_wr_q   <= write_en;
      scan_ptr_q  <= scan_ptr_d;
      div_cnt_q   <= div_cnt_d;
      d_out       <= sel_data;
      d_addr      <= sel_addr;
      wr_ack      <= wr_ev & addr_ok;
      err         <= wr_ev & ~addr_ok;
      // Bank write samples the pre-save hold value on a coincident save event.
      if (wr_ev && addr_ok) bank_q[addr] <= hold_q;
      if (save_ev) hold_q <= d_in;
    end
  end

endmodule

// File: tb/tb_reg_bank_scan.sv
// Bench for reg_bank_scan: a DEPTH=4/SCAN_DIV=4 instance and a DEPTH=5/SCAN_DIV=3 instance
// share stimulus and are checked every cycle against a behavioural model.
module tb_reg_bank_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       save_data = 1'b0, write_en = 1'b0, show_reg = 1'b0, scan_en = 1'b0;
  logic [7:0] d_in = '0;
  logic [7:0] d_out0, d_out1;
  logic [1:0] d_addr0;
  logic [2:0] d_addr1;
  logic       wr_ack0, wr_ack1, err0, err1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_bank_scan u_dut4 (
    .clk(clk), .rst(rst), .save_data(save_data), .write_en(write_en), .show_reg(show_reg),
    .scan_en(scan_en), .d_in(d_in), .d_out(d_out0), .d_addr(d_addr0), .wr_ack(wr_ack0),
    .err(err0)
  );

  reg_bank_scan #(.DEPTH(5), .SCAN_DIV(3)) u_dut5 (
    .clk(clk), .rst(rst), .save_data(save_data), .write_en(write_en), .show_reg(show_reg),
    .scan_en(scan_en), .d_in(d_in), .d_out(d_out1), .d_addr(d_addr1), .wr_ack(wr_ack1),
    .err(err1)
  );

  // Model parameters per instance k: depth, scan period, address bits.
  function automatic int md(int k);  return (k == 0) ? 4 : 5; endfunction
  function automatic int ms(int k);  return (k == 0) ? 4 : 3; endfunction
  function automatic int maw(int k); return (k == 0) ? 2 : 3; endfunction

  int m_hold[2] = '{0, 0};
  int m_bank[2][8];
  int m_prev_s[2] = '{0, 0};
  int m_prev_w[2] = '{0, 0};
  int m_scan_t[2] = '{0, 0};  // consecutive cycles spent scanning
  int m_out[2] = '{0, 0};
  int m_addr[2] = '{0, 0};
  int m_ack[2] = '{0, 0};
  int m_err[2] = '{0, 0};

  initial for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m_bank[k][i] = 0;

  always @(posedge clk or posedge rst) begin
    int a, p;
    bit sev, wev;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_hold[k] = 0; m_prev_s[k] = 0; m_prev_w[k] = 0; m_scan_t[k] = 0;
        m_out[k] = 0; m_addr[k] = 0; m_ack[k] = 0; m_err[k] = 0;
        for (int i = 0; i < 8; i++) m_bank[k][i] = 0;
      end else begin
        a   = int'(d_in) % (1 << maw(k));
        sev = save_data && (m_prev_s[k] == 0);
        wev = write_en && (m_prev_w[k] == 0);
        if (show_reg) begin
          m_out[k]  = (a < md(k)) ? m_bank[k][a] : 0;
          m_addr[k] = a;
        end else if (scan_en) begin
          p = (m_scan_t[k] / ms(k)) % md(k);
          m_out[k]  = m_bank[k][p];
          m_addr[k] = p;
        end else begin
          m_out[k]  = m_hold[k];
          m_addr[k] = 0;
        end
        m_scan_t[k] = (scan_en && !show_reg) ? m_scan_t[k] + 1 : 0;
        m_ack[k] = (wev && a < md(k)) ? 1 : 0;
        m_err[k] = (wev && a >= md(k)) ? 1 : 0;
        if (m_ack[k] != 0) m_bank[k][a] = m_hold[k];
        if (sev) m_hold[k] = int'(d_in);
        m_prev_s[k] = int'(save_data);
        m_prev_w[k] = int'(write_en);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("d_out_d4", int'(d_out0), m_out[0]);
    check("d_addr_d4", int'(d_addr0), m_addr[0]);
    check("wr_ack_d4", int'(wr_ack0), m_ack[0]);
    check("err_d4", int'(err0), m_err[0]);
    check("d_out_d5", int'(d_out1), m_out[1]);
    check("d_addr_d5", int'(d_addr1), m_addr[1]);
    check("wr_ack_d5", int'(wr_ack1), m_ack[1]);
    check("err_d5", int'(err1), m_err[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int ack_cnt;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_d_out", int'(d_out0), 0);
    check("reset_d_addr", int'(d_addr1), 0);
    tick();
    rst = 1'b0;

    // Save then write, then show the written register.
    d_in = 8'h15; save_data = 1'b1; tick();
    save_data = 1'b0; tick();
    d_in = 8'h01; write_en = 1'b1; tick();
    check("t1_ack", int'(wr_ack0), 1);
    write_en = 1'b0; tick();
    check("t1_ack_low", int'(wr_ack0), 0);
    show_reg = 1'b1; tick();
    check("t1_show", int'(d_out0), 8'h15);
    check("t1_addr", int'(d_addr0), 1);
    check("t1_model", m_out[0], 8'h15);
    show_reg = 1'b0;

    // Held write button gives one write; later hold changes do not leak in.
    d_in = 8'hA3; save_data = 1'b1; tick();
    save_data = 1'b0; tick();
    d_in = 8'h02; write_en = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ack_cnt += int'(wr_ack0);
    end
    check("t2_one_ack", ack_cnt, 1);
    d_in = 8'h87; save_data = 1'b1; tick();
    save_data = 1'b0; tick();
    write_en = 1'b0; d_in = 8'h02; show_reg = 1'b1; tick();
    check("t2_bank2", int'(d_out0), 8'hA3);
    show_reg = 1'b0;

    // Load bank and scan.
    for (int i = 0; i < 4; i++) begin
      d_in = vals[i]; save_data = 1'b1; tick();
      save_data = 1'b0; d_in = 8'(i); write_en = 1'b1; tick();
      write_en = 1'b0;
    end
    d_in = 8'h00; scan_en = 1'b1;
    for (int j = 0; j < 17; j++) begin
      tick();
      check("t3_scan_data", int'(d_out0), int'(vals[(j / 4) % 4]));
      check("t3_scan_addr", int'(d_addr0), (j / 4) % 4);
    end
    check("t3_model", m_out[0], 8'h11);
    d_in = 8'h03; show_reg = 1'b1; tick();
    check("t3_show", int'(d_out0), 8'h44);
    check("t3_show_addr", int'(d_addr0), 3);
    show_reg = 1'b0; tick();
    check("t3_restart", int'(d_out0), 8'h11);
    check("t3_restart_addr", int'(d_addr0), 0);
    scan_en = 1'b0;

    // Out-of-range address on the DEPTH=5 instance.
    d_in = 8'h06; write_en = 1'b1; tick();
    check("t4_err", int'(err1), 1);
    check("t4_no_ack", int'(wr_ack1), 0);
    write_en = 1'b0; show_reg = 1'b1; tick();
    check("t4_zero_read", int'(d_out1), 0);
    check("t4_addr", int'(d_addr1), 6);
    show_reg = 1'b0;

    // Coincident save and write.
    d_in = 8'h5A; save_data = 1'b1; tick();
    save_data = 1'b0; tick();
    d_in = 8'h01; save_data = 1'b1; write_en = 1'b1; tick();
    save_data = 1'b0; write_en = 1'b0; show_reg = 1'b1; tick();
    check("t5_bank1", int'(d_out0), 8'h5A);
    show_reg = 1'b0; tick();
    check("t5_hold", int'(d_out0), 8'h01);

    // Async reset mid-scan, release with save already high.
    scan_en = 1'b1;
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_d_out", int'(d_out0), 0);
    check("t6_rst_addr", int'(d_addr0), 0);
    check("t6_rst_d_out5", int'(d_out1), 0);
    d_in = 8'h3C; save_data = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    save_data = 1'b0; scan_en = 1'b0; tick();
    check("t6_save_after_rst", int'(d_out0), 8'h3C);
    check("t6_model", m_out[1], 8'h3C);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      save_data = ($urandom_range(0, 2) == 0);
      write_en  = ($urandom_range(0, 2) == 0);
      show_reg  = ($urandom_range(0, 4) == 0);
      scan_en   = ($urandom_range(0, 3) != 0);
      d_in      = 8'($urandom);
      tick();
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
